// File: rtl/dport_pkg.sv
// Shared types and encodings for the dual-port data-side memory bridge.
package dport_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_P0_REQ,
    S_P0_WAIT,
    S_P1_REQ,
    S_P1_WAIT,
    S_DONE
  } dport_state_t;

  localparam logic [2:0] DPORT_OP_READ  = 3'd0;
  localparam logic [2:0] DPORT_OP_WRITE = 3'd1;
  localparam int DPORT_OP_CACOP_BIT = 2;
  localparam int DPORT_OP_WE_BIT    = 0;

  localparam logic [1:0] DPORT_SIZE_BYTE = 2'd0;
  localparam logic [1:0] DPORT_SIZE_HALF = 2'd1;
  localparam logic [1:0] DPORT_SIZE_WORD = 2'd2;

endpackage

// File: rtl/dport_slot.sv
// Registered copy of one port's request, loaded when a group is accepted.
module dport_slot #(
  parameter int OFFSET_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic                valid_i,
  input  logic [OFFSET_W-1:0] offset_i,
  input  logic [1:0]          size_i,
  input  logic [3:0]          wstrb_i,
  input  logic [31:0]         wdata_i,
  output logic                valid_o,
  output logic [OFFSET_W-1:0] offset_o,
  output logic [1:0]          size_o,
  output logic [3:0]          wstrb_o,
  output logic [31:0]         wdata_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o  <= 1'b0;
      offset_o <= '0;
      size_o   <= '0;
      wstrb_o  <= '0;
      wdata_o  <= '0;
    end else if (load_i) begin
      valid_o  <= valid_i;
      offset_o <= offset_i;
      size_o   <= size_i;
      wstrb_o  <= wstrb_i;
      wdata_o  <= wdata_i;
    end
  end

endmodule

// File: rtl/dport_mem_bridge.sv
// Serves MMU dual-port data requests from a single-port memory bus.
// Optional DPORT_BRIDGE_WORD_MERGE_EN folds same-word dual reads into one.
module dport_mem_bridge
  import dport_pkg::*;
#(
  parameter int TAG_W    = 20,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                p0_valid,
  input  logic                p1_valid,
  input  logic [2:0]          op,
  input  logic [TAG_W-1:0]    tag,
  input  logic [INDEX_W-1:0]  index,
  input  logic [OFFSET_W-1:0] p0_offset,
  input  logic [OFFSET_W-1:0] p1_offset,
  input  logic [3:0]          p0_wstrb,
  input  logic [3:0]          p1_wstrb,
  input  logic [31:0]         p0_wdata,
  input  logic [31:0]         p1_wdata,
  input  logic [1:0]          p0_size,
  input  logic [1:0]          p1_size,
  input  logic                uncached,
  output logic                addr_ok,
  output logic                data_ok,
  output logic [31:0]         p0_rdata,
  output logic [31:0]         p1_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [1:0]          mem_size,
  output logic [31:0]         mem_addr,
  output logic [3:0]          mem_wstrb,
  output logic [31:0]         mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [31:0]         mem_rdata
);

  dport_state_t state_q, state_d;
  logic [TAG_W-1:0]   tag_q;
  logic [INDEX_W-1:0] index_q;
  logic [2:0]         op_q;
  logic               merge_q, merge_d;
  logic [31:0]        p0_rdata_q, p0_rdata_d;
  logic [31:0]        p1_rdata_q, p1_rdata_d;
  logic               accept;

  logic                s0_valid, s1_valid;
  logic [OFFSET_W-1:0] s0_offset, s1_offset;
  logic [1:0]          s0_size, s1_size;
  logic [3:0]          s0_wstrb, s1_wstrb;
  logic [31:0]         s0_wdata, s1_wdata;

  assign addr_ok  = (state_q == S_IDLE);
  assign data_ok  = (state_q == S_DONE);
  assign accept   = addr_ok && (p0_valid || p1_valid);
  assign p0_rdata = p0_rdata_q;
  assign p1_rdata = p1_rdata_q;

`ifdef DPORT_BRIDGE_WORD_MERGE_EN
  assign merge_d = p0_valid && p1_valid && (op == DPORT_OP_READ) &&
                   (p0_offset[OFFSET_W-1:2] == p1_offset[OFFSET_W-1:2]);
`else
  assign merge_d = 1'b0;
`endif

  dport_slot #(.OFFSET_W(OFFSET_W)) u_slot0 (
    .clk(clk), .rst_n(reset), .load_i(accept),
    .valid_i(p0_valid), .offset_i(p0_offset), .size_i(p0_size),
    .wstrb_i(p0_wstrb), .wdata_i(p0_wdata),
    .valid_o(s0_valid), .offset_o(s0_offset), .size_o(s0_size),
    .wstrb_o(s0_wstrb), .wdata_o(s0_wdata)
  );

  dport_slot #(.OFFSET_W(OFFSET_W)) u_slot1 (
    .clk(clk), .rst_n(reset), .load_i(accept),
    .valid_i(p1_valid), .offset_i(p1_offset), .size_i(p1_size),
    .wstrb_i(p1_wstrb), .wdata_i(p1_wdata),
    .valid_o(s1_valid), .offset_o(s1_offset), .size_o(s1_size),
    .wstrb_o(s1_wstrb), .wdata_o(s1_wdata)
  );

  always_comb begin
    state_d    = state_q;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept && !op[DPORT_OP_CACOP_BIT])
          state_d = p0_valid ? S_P0_REQ : S_P1_REQ;
      end
      S_P0_REQ: if (mem_addr_ok) state_d = S_P0_WAIT;
      S_P1_REQ: if (mem_addr_ok) state_d = S_P1_WAIT;
      S_P0_WAIT: begin
        if (mem_data_ok) begin
          if (!op_q[DPORT_OP_WE_BIT]) begin
            p0_rdata_d = mem_rdata;
            if (merge_q) p1_rdata_d = mem_rdata;
          end
          state_d = (s1_valid && !merge_q) ? S_P1_REQ : S_DONE;
        end
      end
      S_P1_WAIT: begin
        if (mem_data_ok) begin
          if (!op_q[DPORT_OP_WE_BIT]) p1_rdata_d = mem_rdata;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus fields come straight from the latched request and are zero off-request.
  always_comb begin
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_size  = '0;
    mem_addr  = '0;
    mem_wstrb = '0;
    mem_wdata = '0;
    unique case (1'b1)
      (state_q == S_P0_REQ): begin
        mem_req   = 1'b1;
        mem_wr    = op_q[DPORT_OP_WE_BIT];
        mem_size  = merge_q ? DPORT_SIZE_WORD : s0_size;
        mem_addr  = {tag_q, index_q, s0_offset};
        mem_wstrb = s0_wstrb;
        mem_wdata = s0_wdata;
        if (merge_q) mem_addr[1:0] = 2'b00;
      end
      (state_q == S_P1_REQ): begin
        mem_req   = 1'b1;
        mem_wr    = op_q[DPORT_OP_WE_BIT];
        mem_size  = s1_size;
        mem_addr  = {tag_q, index_q, s1_offset};
        mem_wstrb = s1_wstrb;
        mem_wdata = s1_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      tag_q      <= '0;
      index_q    <= '0;
      op_q       <= '0;
      merge_q    <= 1'b0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
      if (accept) begin
        tag_q   <= tag;
        index_q <= index;
        op_q    <= op;
        merge_q <= merge_d;
      end
    end
  end

  logic unused_sig;
  assign unused_sig = ^{uncached, op_q[2:1], s0_valid};

endmodule

// File: tb/tb_dport_mem_bridge.sv
// Directed self-checking bench for dport_mem_bridge.
// Merge scenario follows DPORT_BRIDGE_WORD_MERGE_EN.
module tb_dport_mem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_valid, p1_valid;
  logic [2:0]  op;
  logic [19:0] tag;
  logic [7:0]  index;
  logic [3:0]  p0_offset, p1_offset;
  logic [3:0]  p0_wstrb, p1_wstrb;
  logic [31:0] p0_wdata, p1_wdata;
  logic [1:0]  p0_size, p1_size;
  logic        uncached;
  logic        addr_ok, data_ok;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dport_mem_bridge dut (
    .clk(clk), .reset(reset),
    .p0_valid(p0_valid), .p1_valid(p1_valid),
    .op(op), .tag(tag), .index(index),
    .p0_offset(p0_offset), .p1_offset(p1_offset),
    .p0_wstrb(p0_wstrb), .p1_wstrb(p1_wstrb),
    .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
    .p0_size(p0_size), .p1_size(p1_size),
    .uncached(uncached),
    .addr_ok(addr_ok), .data_ok(data_ok),
    .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    p0_valid = 0; p1_valid = 0; op = 0;
    p0_offset = 0; p1_offset = 0; p0_wstrb = 0; p1_wstrb = 0;
    p0_wdata = 0; p1_wdata = 0; p0_size = 0; p1_size = 0;
  endtask

  task automatic test_reset();
    reset = 0; uncached = 0; tag = 0; index = 0;
    clear_req();
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (addr_ok !== 1'b1) begin bad++; $display("FAIL rst_addr_ok got %0b want 1", addr_ok); end
    total++; if (data_ok !== 1'b0) begin bad++; $display("FAIL rst_data_ok got %0b want 0", data_ok); end
    total++; if ({mem_req, mem_wr, mem_size, mem_wstrb} !== 8'h00) begin bad++; $display("FAIL rst_mem_ctl got %h want 00", {mem_req, mem_wr, mem_size, mem_wstrb}); end
    total++; if ({mem_addr, mem_wdata} !== 64'h0) begin bad++; $display("FAIL rst_mem_addr_data got %h want 0", {mem_addr, mem_wdata}); end
    total++; if ({p0_rdata, p1_rdata} !== 64'h0) begin bad++; $display("FAIL rst_rdata got %h want 0", {p0_rdata, p1_rdata}); end
    #3 reset = 1;
    step();
  endtask

  task automatic test_single_read();
    tag = 20'h1C000; index = 8'h12;
    p0_valid = 1; op = 3'b000; p0_offset = 4'h4; p0_size = 2;
    total++; if (addr_ok !== 1'b1) begin bad++; $display("FAIL rd_accept got %0b want 1", addr_ok); end
    step();
    clear_req();
    total++; if (mem_req !== 1'b1 || mem_wr !== 1'b0 || mem_size !== 2'd2) begin bad++; $display("FAIL rd_req got req=%0b wr=%0b sz=%0d want 1 0 2", mem_req, mem_wr, mem_size); end
    total++; if (mem_addr !== 32'h1C000124) begin bad++; $display("FAIL rd_addr got %h want 1c000124", mem_addr); end
    total++; if (addr_ok !== 1'b0) begin bad++; $display("FAIL rd_busy got %0b want 0", addr_ok); end
    mem_addr_ok = 1;
    step();
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hDEADBEEF;
    total++; if (mem_req !== 1'b0 || data_ok !== 1'b0) begin bad++; $display("FAIL rd_wait got req=%0b dok=%0b want 0 0", mem_req, data_ok); end
    step();
    mem_data_ok = 0;
    total++; if (data_ok !== 1'b1) begin bad++; $display("FAIL rd_data_ok_t3 got %0b want 1", data_ok); end
    total++; if (p0_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_p0_rdata got %h want deadbeef", p0_rdata); end
    total++; if (addr_ok !== 1'b0) begin bad++; $display("FAIL rd_no_accept_on_dok got %0b want 0", addr_ok); end
    step();
    total++; if (data_ok !== 1'b0 || addr_ok !== 1'b1) begin bad++; $display("FAIL rd_t4 got dok=%0b aok=%0b want 0 1", data_ok, addr_ok); end
  endtask

  task automatic test_dual_write();
    tag = 20'h1C000; index = 8'h12;
    p0_valid = 1; p1_valid = 1; op = 3'b001;
    p0_offset = 4'h0; p0_size = 1; p0_wstrb = 4'b0011; p0_wdata = 32'h1234;
    p1_offset = 4'h8; p1_size = 2; p1_wstrb = 4'b1100; p1_wdata = 32'hAABB0000;
    step();
    clear_req();
    total++; if (mem_req !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 32'h1C000120) begin bad++; $display("FAIL wr0_req got req=%0b wr=%0b addr=%h want 1 1 1c000120", mem_req, mem_wr, mem_addr); end
    total++; if (mem_wstrb !== 4'b0011 || mem_wdata !== 32'h1234 || mem_size !== 2'd1) begin bad++; $display("FAIL wr0_fields got st=%b wd=%h sz=%0d want 0011 1234 1", mem_wstrb, mem_wdata, mem_size); end
    mem_addr_ok = 1;
    step();
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hBAD0BAD0;
    step();
    mem_data_ok = 0;
    total++; if (mem_req !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 32'h1C000128) begin bad++; $display("FAIL wr1_req got req=%0b wr=%0b addr=%h want 1 1 1c000128", mem_req, mem_wr, mem_addr); end
    total++; if (mem_wstrb !== 4'b1100 || mem_wdata !== 32'hAABB0000 || data_ok !== 1'b0) begin bad++; $display("FAIL wr1_fields got st=%b wd=%h dok=%0b want 1100 aabb0000 0", mem_wstrb, mem_wdata, data_ok); end
    mem_addr_ok = 1;
    step();
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hBAD1BAD1;
    total++; if (data_ok !== 1'b0) begin bad++; $display("FAIL wr_early_dok got %0b want 0", data_ok); end
    step();
    mem_data_ok = 0;
    total++; if (data_ok !== 1'b1) begin bad++; $display("FAIL wr_data_ok_t5 got %0b want 1", data_ok); end
    total++; if (p0_rdata !== 32'hDEADBEEF || p1_rdata !== 32'h0) begin bad++; $display("FAIL wr_rdata_kept got %h %h want deadbeef 0", p0_rdata, p1_rdata); end
    step();
    total++; if (data_ok !== 1'b0) begin bad++; $display("FAIL wr_single_dok got %0b want 0", data_ok); end
  endtask

  task automatic test_dual_read();
    tag = 20'h00ABC; index = 8'h01;
    p0_valid = 1; p1_valid = 1; op = 3'b000;
    p0_offset = 4'h0; p0_size = 2; p1_offset = 4'h8; p1_size = 2;
    step();
    clear_req();
    total++; if (mem_addr !== 32'h00ABC010 || mem_wr !== 1'b0) begin bad++; $display("FAIL drd0_addr got %h wr=%0b want 00abc010 0", mem_addr, mem_wr); end
    mem_addr_ok = 1;
    step();
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h11111111;
    step();
    mem_data_ok = 0;
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h00ABC018) begin bad++; $display("FAIL drd1_addr got req=%0b addr=%h want 1 00abc018", mem_req, mem_addr); end
    mem_addr_ok = 1;
    step();
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h22222222;
    step();
    mem_data_ok = 0;
    total++; if (data_ok !== 1'b1) begin bad++; $display("FAIL drd_dok got %0b want 1", data_ok); end
    total++; if (p0_rdata !== 32'h11111111 || p1_rdata !== 32'h22222222) begin bad++; $display("FAIL drd_rdata got %h %h want 11111111 22222222", p0_rdata, p1_rdata); end
    step();
  endtask

  task automatic test_addr_delay();
    tag = 20'hFFFFF; index = 8'hFF;
    p0_valid = 1; op = 3'b001; p0_offset = 4'hC; p0_size = 2;
    p0_wstrb = 4'hF; p0_wdata = 32'hCAFEF00D;
    step();
    clear_req();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (mem_req !== 1'b1 || mem_wr !== 1'b1 || mem_size !== 2'd2 ||
          mem_addr !== 32'hFFFFFFFC || mem_wstrb !== 4'hF ||
          mem_wdata !== 32'hCAFEF00D || addr_ok !== 1'b0) begin
        bad++;
        $display("FAIL dly_hold%0d got req=%0b addr=%h wd=%h aok=%0b want 1 fffffffc cafef00d 0",
                 i, mem_req, mem_addr, mem_wdata, addr_ok);
      end
      if (i == 3) begin
        mem_addr_ok = 1; mem_data_ok = 0;
      end else begin
        mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h0BAD0BAD;
      end
      step();
    end
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h77777777;
    total++; if (mem_req !== 1'b0 || data_ok !== 1'b0) begin bad++; $display("FAIL dly_wait got req=%0b dok=%0b want 0 0", mem_req, data_ok); end
    step();
    mem_data_ok = 0;
    total++; if (data_ok !== 1'b1 || p0_rdata !== 32'h11111111) begin bad++; $display("FAIL dly_done got dok=%0b p0=%h want 1 11111111", data_ok, p0_rdata); end
    step();
  endtask

  task automatic test_cacop();
    tag = 20'h12345; index = 8'h67;
    p0_valid = 1; op = 3'b101; p0_offset = 4'h4;
    mem_addr_ok = 1; mem_data_ok = 1; mem_rdata = 32'hFFFF0000;
    total++; if (addr_ok !== 1'b1) begin bad++; $display("FAIL cop_accept got %0b want 1", addr_ok); end
    step();
    clear_req();
    total++; if (addr_ok !== 1'b1 || mem_req !== 1'b0 || data_ok !== 1'b0) begin bad++; $display("FAIL cop_drop got aok=%0b req=%0b dok=%0b want 1 0 0", addr_ok, mem_req, data_ok); end
    mem_addr_ok = 0; mem_data_ok = 0;
    p1_valid = 1; op = 3'b000; p1_offset = 4'h4; p1_size = 2;
    step();
    clear_req();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h12345674 || data_ok !== 1'b0) begin bad++; $display("FAIL cop_next got req=%0b addr=%h dok=%0b want 1 12345674 0", mem_req, mem_addr, data_ok); end
    mem_addr_ok = 1;
    step();
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h5A5A5A5A;
    step();
    mem_data_ok = 0;
    total++; if (data_ok !== 1'b1 || p1_rdata !== 32'h5A5A5A5A) begin bad++; $display("FAIL cop_p1_done got dok=%0b p1=%h want 1 5a5a5a5a", data_ok, p1_rdata); end
    step();
  endtask

  task automatic test_merge();
    tag = 20'h1C000; index = 8'h12;
    p0_valid = 1; p1_valid = 1; op = 3'b000;
    p0_offset = 4'h4; p0_size = 0; p1_offset = 4'h6; p1_size = 1;
    step();
    clear_req();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h1C000124) begin bad++; $display("FAIL mg_addr0 got req=%0b addr=%h want 1 1c000124", mem_req, mem_addr); end
`ifdef DPORT_BRIDGE_WORD_MERGE_EN
    total++; if (mem_size !== 2'd2) begin bad++; $display("FAIL mg_size got %0d want 2", mem_size); end
`else
    total++; if (mem_size !== 2'd0) begin bad++; $display("FAIL mg_size got %0d want 0", mem_size); end
`endif
    mem_addr_ok = 1;
    step();
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h0BADF00D;
    step();
    mem_data_ok = 0;
`ifdef DPORT_BRIDGE_WORD_MERGE_EN
    total++; if (data_ok !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("FAIL mg_dok_t3 got dok=%0b req=%0b want 1 0", data_ok, mem_req); end
    total++; if (p0_rdata !== 32'h0BADF00D || p1_rdata !== 32'h0BADF00D) begin bad++; $display("FAIL mg_rdata got %h %h want 0badf00d x2", p0_rdata, p1_rdata); end
    step();
    total++; if (mem_req !== 1'b0 || addr_ok !== 1'b1) begin bad++; $display("FAIL mg_single got req=%0b aok=%0b want 0 1", mem_req, addr_ok); end
`else
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h1C000126 || mem_size !== 2'd1) begin bad++; $display("FAIL nm_addr1 got req=%0b addr=%h sz=%0d want 1 1c000126 1", mem_req, mem_addr, mem_size); end
    mem_addr_ok = 1;
    step();
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h600D600D;
    step();
    mem_data_ok = 0;
    total++; if (data_ok !== 1'b1) begin bad++; $display("FAIL nm_dok_t5 got %0b want 1", data_ok); end
    total++; if (p0_rdata !== 32'h0BADF00D || p1_rdata !== 32'h600D600D) begin bad++; $display("FAIL nm_rdata got %h %h want 0badf00d 600d600d", p0_rdata, p1_rdata); end
    step();
`endif
  endtask

  task automatic test_reset_mid();
    tag = 20'h00ABC; index = 8'h01;
    p0_valid = 1; p1_valid = 1; op = 3'b000;
    p0_offset = 4'h0; p0_size = 2; p1_offset = 4'h8; p1_size = 2;
    step();
    clear_req();
    mem_addr_ok = 1;
    step();
    mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h33333333;
    step();
    mem_data_ok = 0; mem_addr_ok = 1;
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rm_p1_req got %0b want 1", mem_req); end
    step();
    mem_addr_ok = 0;
    total++; if (addr_ok !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL rm_in_wait got aok=%0b req=%0b want 0 0", addr_ok, mem_req); end
    reset = 0;
    #1;
    total++; if (addr_ok !== 1'b1 || mem_req !== 1'b0 || p0_rdata !== 32'h0) begin bad++; $display("FAIL rm_async got aok=%0b req=%0b p0=%h want 1 0 0", addr_ok, mem_req, p0_rdata); end
    #1 reset = 1;
    mem_data_ok = 1; mem_rdata = 32'h44444444;
    step();
    mem_data_ok = 0;
    total++; if (data_ok !== 1'b0 || addr_ok !== 1'b1) begin bad++; $display("FAIL rm_late_rsp got dok=%0b aok=%0b want 0 1", data_ok, addr_ok); end
    step();
    total++; if (data_ok !== 1'b0 || p1_rdata !== 32'h0) begin bad++; $display("FAIL rm_quiet got dok=%0b p1=%h want 0 0", data_ok, p1_rdata); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_dual_write();
    test_dual_read();
    test_addr_delay();
    test_cacop();
    test_merge();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
